// File: rtl/video_timing_pkg.sv
// video_timing_pkg: shared types and constants for the raster timing generator.
//   axis_bounds_t  - per-axis segment boundaries (active end, sync window, total)
//   calc_bounds()  - derives boundaries from active/front/sync/back lengths
//   H_TOTAL/V_TOTAL and SXGA_* - boundaries of the default 1280x1024 mode
package video_timing_pkg;

   typedef struct packed {
      logic [31:0] active;      // first blanking position
      logic [31:0] sync_start;  // first sync position
      logic [31:0] sync_end;    // first position after sync
      logic [31:0] total;       // positions per axis period
   } axis_bounds_t;

   function automatic axis_bounds_t calc_bounds(input int unsigned active,
                                                input int unsigned front,
                                                input int unsigned sync,
                                                input int unsigned back);
      axis_bounds_t b;
      b.active     = active;
      b.sync_start = active + front;
      b.sync_end   = active + front + sync;
      b.total      = active + front + sync + back;
      return b;
   endfunction

   localparam axis_bounds_t SXGA_H  = calc_bounds(1280, 48, 112, 248);
   localparam axis_bounds_t SXGA_V  = calc_bounds(1024, 1, 3, 38);
   localparam int unsigned  H_TOTAL = SXGA_H.total;
   localparam int unsigned  V_TOTAL = SXGA_V.total;

endpackage

// File: rtl/video_timing_if.sv
// video_timing_if: run enable plus all raster outputs of video_timing_gen.
//   master (generator): input en; output hsync, vsync, de, cnt_x, cnt_y, sof, sol, req
//   slave  (consumer) : the mirror image
interface video_timing_if #(
   parameter int unsigned CNT_W = 12
);
   logic             en;
   logic             hsync;
   logic             vsync;
   logic             de;
   logic [CNT_W-1:0] cnt_x;
   logic [CNT_W-1:0] cnt_y;
   logic             sof;
   logic             sol;
   logic             req;

   modport master (input en, output hsync, vsync, de, cnt_x, cnt_y, sof, sol, req);
   modport slave  (output en, input hsync, vsync, de, cnt_x, cnt_y, sof, sol, req);
endinterface

// File: rtl/video_timing_gen_axis.sv
// timing_axis: one wrapping raster counter (0..total-1) with window decode.
//   clk, rst  - clock, asynchronous active-high reset
//   clr       - synchronous rewind to 0 (dominates ci)
//   ci        - carry-in: advance by one this clock
//   cnt       - current position
//   co        - terminal count (cnt == total-1); a chained axis advances on
//               the clock where this axis both has ci and is at terminal count
//   active    - cnt inside the active segment
//   in_sync   - cnt inside the sync segment
module timing_axis
   import video_timing_pkg::*;
#(
   parameter int unsigned  CNT_W  = 12,
   parameter axis_bounds_t BOUNDS = calc_bounds(8, 2, 3, 3)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             ci,
   output logic [CNT_W-1:0] cnt,
   output logic             co,
   output logic             active,
   output logic             in_sync
);
   // One extra bit so boundaries equal to total never truncate.
   localparam logic [CNT_W:0] LAST = (CNT_W+1)'(BOUNDS.total - 1);
   localparam logic [CNT_W:0] ACT  = (CNT_W+1)'(BOUNDS.active);
   localparam logic [CNT_W:0] SS   = (CNT_W+1)'(BOUNDS.sync_start);
   localparam logic [CNT_W:0] SE   = (CNT_W+1)'(BOUNDS.sync_end);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W:0]   cnt_w;

   assign cnt_w   = {1'b0, cnt_q};
   assign cnt     = cnt_q;
   assign co      = (cnt_w == LAST);
   assign active  = (cnt_w < ACT);
   assign in_sync = (cnt_w >= SS) && (cnt_w < SE);

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (ci) begin
         cnt_d = co ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised raster timing generator.
//   xclk - pixel clock
//   rst  - asynchronous active-high reset
//   vif  - master side: en in; hsync, vsync, de, cnt_x, cnt_y, sof, sol, req out
// All outputs are registered decodes of the (h,v) position held before the
// clock edge. en low rewinds the raster and holds outputs idle.
module video_timing_gen
   import video_timing_pkg::*;
#(
   parameter int unsigned CNT_W    = 12,
   parameter int unsigned H_ACTIVE = 1280,
   parameter int unsigned H_FRONT  = 48,
   parameter int unsigned H_SYNC   = 112,
   parameter int unsigned H_BACK   = 248,
   parameter int unsigned V_ACTIVE = 1024,
   parameter int unsigned V_FRONT  = 1,
   parameter int unsigned V_SYNC   = 3,
   parameter int unsigned V_BACK   = 38,
   parameter bit          HS_POL   = 1'b0,
   parameter bit          VS_POL   = 1'b0,
   parameter int unsigned PREFETCH = 4
) (
   input  logic           xclk,
   input  logic           rst,
   video_timing_if.master vif
);
   localparam axis_bounds_t HB = calc_bounds(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
   localparam axis_bounds_t VB = calc_bounds(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

   localparam logic [CNT_W:0]   H_TOT_W = (CNT_W+1)'(HB.total);
   localparam logic [CNT_W:0]   H_ACT_W = (CNT_W+1)'(H_ACTIVE);
   localparam logic [CNT_W:0]   PF_W    = (CNT_W+1)'(PREFETCH);
   localparam logic [CNT_W-1:0] V_ACT_N = CNT_W'(V_ACTIVE);

   logic             run;
   logic [CNT_W-1:0] h, v;
   logic             h_co, v_co, h_act, v_act, h_sync, v_sync;

   assign run = vif.en;

   timing_axis #(.CNT_W(CNT_W), .BOUNDS(HB)) u_h (
      .clk(xclk), .rst(rst), .clr(!run), .ci(run),
      .cnt(h), .co(h_co), .active(h_act), .in_sync(h_sync)
   );

   timing_axis #(.CNT_W(CNT_W), .BOUNDS(VB)) u_v (
      .clk(xclk), .rst(rst), .clr(!run), .ci(h_co),
      .cnt(v), .co(v_co), .active(v_act), .in_sync(v_sync)
   );

   // Prefetch: req is the active decode of the position PREFETCH clocks
   // ahead. Since PREFETCH never exceeds the horizontal blanking, the look-
   // ahead crosses at most one line boundary (and the frame wrap when the
   // current line is the last one).
   logic [CNT_W:0]   h_ahead, h_tgt;
   logic [CNT_W-1:0] v_tgt;
   logic             ahead_wraps, req_hit;

   always_comb begin
      h_ahead     = {1'b0, h} + PF_W;
      ahead_wraps = (h_ahead >= H_TOT_W);
      h_tgt       = ahead_wraps ? h_ahead - H_TOT_W : h_ahead;
      v_tgt       = v;
      if (ahead_wraps) begin
         v_tgt = v_co ? '0 : v + CNT_W'(1);
      end
      req_hit = (h_tgt < H_ACT_W) && (v_tgt < V_ACT_N);
   end

   logic             hsync_q, hsync_d, vsync_q, vsync_d;
   logic             de_q, de_d, sof_q, sof_d, sol_q, sol_d, req_q, req_d;
   logic [CNT_W-1:0] cnt_x_q, cnt_x_d, cnt_y_q, cnt_y_d;

   always_comb begin
      hsync_d = ~HS_POL;
      vsync_d = ~VS_POL;
      de_d    = 1'b0;
      sof_d   = 1'b0;
      sol_d   = 1'b0;
      req_d   = 1'b0;
      cnt_x_d = '0;
      cnt_y_d = '0;
      if (run) begin
         hsync_d = h_sync ? HS_POL : ~HS_POL;
         vsync_d = v_sync ? VS_POL : ~VS_POL;
         de_d    = h_act && v_act;
         sol_d   = h_act && v_act && (h == '0);
         sof_d   = h_act && v_act && (h == '0) && (v == '0);
         req_d   = req_hit;
         cnt_x_d = h;
         cnt_y_d = v;
      end
   end

   always_ff @(posedge xclk or posedge rst) begin
      if (rst) begin
         hsync_q <= ~HS_POL;
         vsync_q <= ~VS_POL;
         de_q    <= 1'b0;
         sof_q   <= 1'b0;
         sol_q   <= 1'b0;
         req_q   <= 1'b0;
         cnt_x_q <= '0;
         cnt_y_q <= '0;
      end else begin
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
         de_q    <= de_d;
         sof_q   <= sof_d;
         sol_q   <= sol_d;
         req_q   <= req_d;
         cnt_x_q <= cnt_x_d;
         cnt_y_q <= cnt_y_d;
      end
   end

   assign vif.hsync = hsync_q;
   assign vif.vsync = vsync_q;
   assign vif.de    = de_q;
   assign vif.sof   = sof_q;
   assign vif.sol   = sol_q;
   assign vif.req   = req_q;
   assign vif.cnt_x = cnt_x_q;
   assign vif.cnt_y = cnt_y_q;
endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen in the small mode H 8/2/3/3, V 4/1/2/1,
// HS_POL=0, VS_POL=1, with three instances: PREFETCH 2 (CNT_W 12) and
// PREFETCH 1 / 8 (CNT_W 5). A raster model based on a linear pixel index
// since restart predicts every output on every clock.
module tb_video_timing_gen;
   localparam int HA = 8, HF = 2, HS = 3, HBK = 3;
   localparam int VA = 4, VF = 1, VS = 2, VBK = 1;
   localparam int HT = HA + HF + HS + HBK;   // 16
   localparam int VT = VA + VF + VS + VBK;   // 8
   localparam int FR = HT * VT;              // 128

   typedef struct packed {
      logic        hs, vs, de, sof, sol, req;
      logic [11:0] x, y;
   } obs_t;

   typedef struct {
      int   cyc;    // clock index since restart at which to compare
      obs_t want;
   } vec_t;

   logic xclk = 1'b0;
   logic rst  = 1'b1;
   logic en   = 1'b1;
   always #5 xclk = ~xclk;

   video_timing_if #(.CNT_W(12)) vif_a ();
   video_timing_if #(.CNT_W(5))  vif_b ();
   video_timing_if #(.CNT_W(5))  vif_c ();
   assign vif_a.en = en;
   assign vif_b.en = en;
   assign vif_c.en = en;

   video_timing_gen #(
      .CNT_W(12), .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HBK),
      .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VBK),
      .HS_POL(1'b0), .VS_POL(1'b1), .PREFETCH(2)
   ) u_dut_a (.xclk(xclk), .rst(rst), .vif(vif_a));

   video_timing_gen #(
      .CNT_W(5), .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HBK),
      .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VBK),
      .HS_POL(1'b0), .VS_POL(1'b1), .PREFETCH(1)
   ) u_dut_b (.xclk(xclk), .rst(rst), .vif(vif_b));

   video_timing_gen #(
      .CNT_W(5), .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HBK),
      .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VBK),
      .HS_POL(1'b0), .VS_POL(1'b1), .PREFETCH(8)
   ) u_dut_c (.xclk(xclk), .rst(rst), .vif(vif_c));

   obs_t got_a, got_b, got_c;
   assign got_a = {vif_a.hsync, vif_a.vsync, vif_a.de, vif_a.sof, vif_a.sol, vif_a.req,
                   12'(vif_a.cnt_x), 12'(vif_a.cnt_y)};
   assign got_b = {vif_b.hsync, vif_b.vsync, vif_b.de, vif_b.sof, vif_b.sol, vif_b.req,
                   12'(vif_b.cnt_x), 12'(vif_b.cnt_y)};
   assign got_c = {vif_c.hsync, vif_c.vsync, vif_c.de, vif_c.sof, vif_c.sol, vif_c.req,
                   12'(vif_c.cnt_x), 12'(vif_c.cnt_y)};

   function automatic obs_t mk(logic hs, logic vs, logic de, logic sof, logic sol,
                               logic req, int x, int y);
      obs_t o;
      o.hs = hs; o.vs = vs; o.de = de; o.sof = sof; o.sol = sol; o.req = req;
      o.x = 12'(x); o.y = 12'(y);
      return o;
   endfunction

   // Raster model: clock k after restart shows pixel index k mod frame;
   // req shows whether pixel index k+pf is active.
   function automatic obs_t ref_out(bit running, int k, int pf);
      int pos, x, y, p2;
      if (!running) return mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      pos = k % FR;
      x   = pos % HT;
      y   = pos / HT;
      p2  = (pos + pf) % FR;
      return mk(!(x >= HA + HF && x < HA + HF + HS),
                (y >= VA + VF && y < VA + VF + VS),
                (x < HA) && (y < VA),
                (x < HA) && (y < VA) && (pos == 0),
                (x < HA) && (y < VA) && (x == 0),
                ((p2 % HT) < HA) && ((p2 / HT) < VA),
                x, y);
   endfunction

   int   n_vec = 0;
   int   n_bad = 0;
   bit   chk_on = 1'b0;
   int   k = 0;
   obs_t exp_a, exp_b, exp_c;

   task automatic cmp(input string nm, input obs_t got, input obs_t want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s t=%0t got hs%b vs%b de%b sof%b sol%b req%b x%0d y%0d want hs%b vs%b de%b sof%b sol%b req%b x%0d y%0d",
                  nm, $time, got.hs, got.vs, got.de, got.sof, got.sol, got.req, got.x, got.y,
                  want.hs, want.vs, want.de, want.sof, want.sol, want.req, want.x, want.y);
      end
   endtask

   always @(posedge xclk or posedge rst) begin
      if (rst || !en) begin
         k     <= 0;
         exp_a <= ref_out(1'b0, 0, 2);
         exp_b <= ref_out(1'b0, 0, 1);
         exp_c <= ref_out(1'b0, 0, 8);
      end else begin
         k     <= k + 1;
         exp_a <= ref_out(1'b1, k, 2);
         exp_b <= ref_out(1'b1, k, 1);
         exp_c <= ref_out(1'b1, k, 8);
      end
   end

   always @(negedge xclk) begin
      if (chk_on) begin
         cmp("model_pf2", got_a, exp_a);
         cmp("model_pf1", got_b, exp_b);
         cmp("model_pf8", got_c, exp_c);
      end
   end

   vec_t tbl[$];
   obs_t idle;
   obs_t first_px;

   task automatic add(input int c, input obs_t w);
      vec_t v;
      v.cyc  = c;
      v.want = w;
      tbl.push_back(v);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: bench did not finish within time limit");
      $fatal(1);
   end

   initial begin
      int cyc;
      idle     = mk(1, 0, 0, 0, 0, 0, 0, 0);
      first_px = mk(1, 0, 1, 1, 1, 1, 0, 0);
      //      cyc      hs vs de sof sol req  x  y
      add(  0, mk(1, 0, 1, 1, 1, 1,  0, 0));
      add(  5, mk(1, 0, 1, 0, 0, 1,  5, 0));
      add(  6, mk(1, 0, 1, 0, 0, 0,  6, 0));
      add(  8, mk(1, 0, 0, 0, 0, 0,  8, 0));
      add( 10, mk(0, 0, 0, 0, 0, 0, 10, 0));
      add( 12, mk(0, 0, 0, 0, 0, 0, 12, 0));
      add( 13, mk(1, 0, 0, 0, 0, 0, 13, 0));
      add( 14, mk(1, 0, 0, 0, 0, 1, 14, 0));
      add( 16, mk(1, 0, 1, 0, 1, 1,  0, 1));
      add( 54, mk(1, 0, 1, 0, 0, 0,  6, 3));
      add( 62, mk(1, 0, 0, 0, 0, 0, 14, 3));
      add( 64, mk(1, 0, 0, 0, 0, 0,  0, 4));
      add( 79, mk(1, 0, 0, 0, 0, 0, 15, 4));
      add( 80, mk(1, 1, 0, 0, 0, 0,  0, 5));
      add( 90, mk(0, 1, 0, 0, 0, 0, 10, 5));
      add(111, mk(1, 1, 0, 0, 0, 0, 15, 6));
      add(112, mk(1, 0, 0, 0, 0, 0,  0, 7));
      add(126, mk(1, 0, 0, 0, 0, 1, 14, 7));
      add(128, mk(1, 0, 1, 1, 1, 1,  0, 0));
      add(129, mk(1, 0, 1, 0, 0, 1,  1, 0));

      // Reset state, then release with en already high.
      @(negedge xclk);
      chk_on = 1'b1;
      cmp("reset_a", got_a, idle);
      cmp("reset_c", got_c, idle);
      #1 rst = 1'b0;

      cyc = -1;
      for (int i = 0; i < tbl.size(); i++) begin
         while (cyc < tbl[i].cyc) begin
            @(negedge xclk);
            cyc++;
         end
         cmp($sformatf("vec%0d", i), got_a, tbl[i].want);
      end

      // en dropped while the counter holds (h=5,v=2) of the second frame.
      while (cyc < FR + 2 * HT + 4) begin
         @(negedge xclk);
         cyc++;
      end
      en = 1'b0;
      for (int i = 0; i < 7; i++) begin
         @(negedge xclk);
         cmp($sformatf("en_low%0d", i), got_a, idle);
      end
      en = 1'b1;
      @(negedge xclk);
      cmp("en_restart", got_a, first_px);

      // Asynchronous reset in the middle of an active run.
      @(posedge xclk);
      #2 rst = 1'b1;
      #1;
      cmp("async_rst_a", got_a, idle);
      cmp("async_rst_b", got_b, idle);
      @(negedge xclk);
      #1 rst = 1'b0;
      @(negedge xclk);
      cmp("rst_restart", got_a, first_px);

      // Randomised en levels and occasional reset pulses.
      for (int i = 0; i < 50; i++) begin
         en = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 7) == 0) begin
            @(posedge xclk);
            #3 rst = 1'b1;
            #1 rst = 1'b0;
         end
         repeat ($urandom_range(1, 300)) @(negedge xclk);
      end
      en = 1'b1;
      repeat (2 * FR + 5) @(negedge xclk);

      chk_on = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
